seg_dynamic_scan: RTL and testbench

SEG_DYNAMIC_SCAN -- requirements
Module: seg_dynamic_scan

---
 rtl/seg_dynamic_scan.sv | 150 +++++++++++++++
 tb/tb_seg_dynamic_scan.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_dynamic_scan.sv
// Six-digit multiplexed 7-segment driver: converts a 20-bit binary score to BCD
// with a sequential double-dabble and scans the digits with leading-zero blanking.
module seg_dynamic_scan #(
  parameter logic [15:0] CNT_MAX = 16'd49999
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        seg_en,
  output logic        busy,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  localparam logic [19:0] BIN_MAX   = 20'd999999;
  localparam logic [4:0]  LAST_ITER = 5'd19;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state;
  state_t            next_state;
  logic              load;
  logic              shift_en;
  logic              commit;
  logic [19:0]       data_lat;
  logic [19:0]       bin;
  logic [23:0]       bcd;
  logic [23:0]       bcd_adj;
  logic [4:0]        iter;
  logic [5:0][3:0]   disp;
  logic [15:0]       cnt;
  logic [2:0]        idx;
  logic [5:0]        shown;
  logic [5:0]        sel_next;
  logic [7:0]        seg_next;

  function automatic logic [7:0] decode(input logic [3:0] d);
    logic [7:0] p;
    case (d)
      4'd0:    p = 8'hC0;
      4'd1:    p = 8'hF9;
      4'd2:    p = 8'hA4;
      4'd3:    p = 8'hB0;
      4'd4:    p = 8'h99;
      4'd5:    p = 8'h92;
      4'd6:    p = 8'h82;
      4'd7:    p = 8'hF8;
      4'd8:    p = 8'h80;
      4'd9:    p = 8'h90;
      default: p = 8'hFF;
    endcase
    return p;
  endfunction

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (data != data_lat) next_state = SHIFT;
      SHIFT:   if (iter == LAST_ITER) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    load     = (state == IDLE) && (data != data_lat);
    shift_en = (state == SHIFT);
    commit   = (state == DONE);
  end

  always_comb begin
    bcd_adj = '0;
    for (int k = 0; k < 6; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      else                       bcd_adj[4*k +: 4] = bcd[4*k +: 4];
    end
  end

  // Values above six digits saturate so the display never wraps.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      data_lat <= '0;
      bin      <= '0;
      bcd      <= '0;
      iter     <= '0;
      disp     <= '0;
      busy     <= 1'b0;
    end else begin
      busy <= (next_state != IDLE);
      if (load) begin
        data_lat <= data;
        bin      <= (data > BIN_MAX) ? BIN_MAX : data;
        bcd      <= '0;
        iter     <= '0;
      end else if (shift_en) begin
        {bcd, bin} <= {bcd_adj[22:0], bin, 1'b0};
        iter       <= iter + 5'd1;
      end else if (commit) begin
        disp <= bcd;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // A digit is shown when it or any more significant digit is nonzero.
  assign shown[5] = |disp[5];
  assign shown[4] = |disp[5:4];
  assign shown[3] = |disp[5:3];
  assign shown[2] = |disp[5:2];
  assign shown[1] = |disp[5:1];
  assign shown[0] = 1'b1;

  always_comb begin
    sel_next = 6'b000000;
    seg_next = 8'hFF;
    if (seg_en) begin
      sel_next    = 6'b000001 << idx;
      seg_next    = shown[idx] ? decode(disp[idx]) : 8'hFF;
      seg_next[7] = ~point[idx];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sel <= 6'b000000;
      seg <= 8'hFF;
    end else begin
      sel <= sel_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_dynamic_scan.sv
// Randomized self-checking bench for seg_dynamic_scan; expected display comes
// from decimal arithmetic on the applied score and a cycle-count scan model.
module tb_seg_dynamic_scan;

  localparam int DWELL = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [19:0] data;
  logic [5:0]  point;
  logic        seg_en;
  logic        busy;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int          check_count = 0;
  int          error_count = 0;
  logic        mon_on = 1'b0;
  logic        settled = 1'b0;
  int          model_val = 0;
  int          cycle_k = 0;
  int          idx_m;
  logic        rst_q;
  logic        en_q;
  logic [5:0]  point_q;

  int          pow10[6] = '{1, 10, 100, 1000, 10000, 100000};
  logic [7:0]  seg_table[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  seg_dynamic_scan #(.CNT_MAX(16'd3)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .data    (data),
    .point   (point),
    .seg_en  (seg_en),
    .busy    (busy),
    .sel     (sel),
    .seg     (seg)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act !== exp) begin
      error_count++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] expSeg(input int val, input int i, input logic [5:0] pt, input logic en);
    logic [7:0] r;
    if (!en) return 8'hFF;
    if (i > 0 && val < pow10[i]) r = 8'hFF;
    else                         r = seg_table[(val / pow10[i]) % 10];
    if (pt[i]) r[7] = 1'b0;
    return r;
  endfunction

  function automatic int sat(input int v);
    return (v > 999999) ? 999999 : v;
  endfunction

  // Registered outputs follow the inputs seen at the edge that produced them.
  always @(posedge sys_clk) begin
    rst_q   <= sys_rst;
    en_q    <= seg_en;
    point_q <= point;
    if (sys_rst) cycle_k <= 0;
    else         cycle_k <= cycle_k + 1;
  end

  always @(negedge sys_clk) begin
    if (mon_on) begin
      if (rst_q) begin
        checkOutput("sel_rst", 32'(sel), 32'h0);
        checkOutput("seg_rst", 32'(seg), 32'hFF);
      end else begin
        idx_m = ((cycle_k - 1) / DWELL) % 6;
        checkOutput("sel_scan", 32'(sel), en_q ? (32'h1 << idx_m) : 32'h0);
        if (settled) checkOutput("seg_scan", 32'(seg), 32'(expSeg(model_val, idx_m, point_q, en_q)));
      end
    end
  end

  task automatic applyStimulus(input logic [19:0] d, input logic [5:0] pt);
    @(posedge sys_clk);
    #1;
    settled = 1'b0;
    data    = d;
    point   = pt;
  endtask

  task automatic runConversion(input int value, input logic [5:0] pt);
    applyStimulus(20'(value), pt);
    @(negedge sys_clk);
    checkOutput("busy_pre", 32'(busy), 32'h0);
    for (int j = 0; j <= 22; j++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      checkOutput("busy_conv", 32'(busy), (j <= 20) ? 32'h1 : 32'h0);
    end
    model_val = sat(value);
    settled   = 1'b1;
    repeat (30) @(negedge sys_clk);
  endtask

  initial begin
    int v;
    int prev;
    logic [5:0] pt;
    sys_rst = 1'b1;
    data    = '0;
    point   = '0;
    seg_en  = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    mon_on = 1'b1;
    checkOutput("busy_rst", 32'(busy), 32'h0);
    sys_rst   = 1'b0;
    model_val = 0;
    settled   = 1'b1;
    repeat (30) begin
      @(negedge sys_clk);
      checkOutput("busy_idle", 32'(busy), 32'h0);
    end

    runConversion(123456, 6'b000000);
    runConversion(1000000, 6'b000000);
    runConversion(907, 6'b000010);

    applyStimulus(20'd907, 6'b000010);
    settled = 1'b1;
    repeat (10) begin
      @(negedge sys_clk);
      checkOutput("busy_const", 32'(busy), 32'h0);
    end

    // Second value arrives mid-conversion and must be picked up afterwards.
    applyStimulus(20'd5, 6'b000000);
    @(negedge sys_clk);
    checkOutput("busy_pre", 32'(busy), 32'h0);
    for (int j = 0; j <= 44; j++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      checkOutput("busy_retrig", 32'(busy),
                  ((j <= 20) || (j >= 22 && j <= 42)) ? 32'h1 : 32'h0);
      if (j == 10) data = 20'd42;
      if (j == 23) begin
        model_val = 5;
        settled   = 1'b1;
      end
      if (j == 42) settled = 1'b0;
    end
    model_val = 42;
    settled   = 1'b1;
    repeat (30) @(negedge sys_clk);

    @(posedge sys_clk);
    #1;
    seg_en = 1'b0;
    point  = 6'h3F;
    repeat (26) @(negedge sys_clk);
    @(posedge sys_clk);
    #1;
    seg_en = 1'b1;
    point  = 6'h00;
    repeat (26) @(negedge sys_clk);

    applyStimulus(20'd777, 6'b000000);
    repeat (6) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    checkOutput("busy_rst_mid", 32'(busy), 32'h0);
    sys_rst   = 1'b0;
    model_val = 0;
    settled   = 1'b1;
    for (int j = 0; j <= 22; j++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      checkOutput("busy_reconv", 32'(busy), (j <= 20) ? 32'h1 : 32'h0);
      if (j == 20) settled = 1'b0;
    end
    model_val = 777;
    settled   = 1'b1;
    repeat (30) @(negedge sys_clk);

    prev = 777;
    for (int n = 0; n < 12; n++) begin
      v = int'($urandom_range(0, 20'hFFFFF));
      if (v == prev) v = v ^ 1;
      pt = 6'($urandom_range(0, 63));
      runConversion(v, pt);
      prev = v;
    end

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
